// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: START / byte / ACK / STOP on open-drain SCL/SDA enables,
// steering an external 8-bit shift register. Define I2C_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_byte_ctrl #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          srst,
  input  logic [PW-1:0] prescale,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_start,
  input  logic          cmd_write,
  input  logic          cmd_read,
  input  logic          cmd_stop,
  input  logic          tx_ack,
  output logic          done,
  output logic          busy,
  output logic          rx_ack,
  output logic          sr_load,
  output logic          sr_shift,
  input  logic          sr_serial_o,
  output logic          sr_serial_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          scl_oen,
  output logic          sda_oen,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_FIN} state_t;
  localparam logic [1:0] PH_A = 2'd0, PH_B = 2'd1, PH_C = 2'd2, PH_D = 2'd3;

  state_t        state, state_nx;
  logic [PW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bitcnt;
  logic          c_byte, c_write, c_stop, c_txack;
  logic          scl_hold, sda_hold, scl_drv, sda_drv;
  logic          accept, phased, last_clk, stall, tick, phase_end;

  // Command handshake: a command transfers on a cycle with cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE; a request made while busy is dropped, not queued.
  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid & cmd_ready & ~srst;
  assign sr_load   = accept & cmd_write;
  assign state_dbg = state;
  assign phased    = (state == S_START) || (state == S_DATA) || (state == S_ACK) || (state == S_STOP);
  assign last_clk  = (qcnt == prescale);

`ifdef I2C_CLK_STRETCH_EN
  // A released SCL still read low means the slave is stretching: freeze the quarter-bit timer.
  assign stall = phased & scl_oen & ~scl_i & ((phase == PH_B) || (phase == PH_C));
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall        = 1'b0;
`endif

  assign tick      = phased & last_clk & ~stall;
  assign phase_end = tick & (phase == PH_D);
  assign scl_oen   = scl_drv;
  assign sda_oen   = sda_drv;

  // Outside phased states the lines keep whatever level the last phase left them at.
  always_comb begin
    state_nx = state;
    scl_drv  = scl_hold;
    sda_drv  = sda_hold;
    sr_shift = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_start)                  state_nx = S_START;
          else if (cmd_write || cmd_read) state_nx = S_DATA;
          else if (cmd_stop)              state_nx = S_STOP;
          else                            state_nx = S_FIN;
        end
      end
      S_START: begin
        busy    = 1'b1;
        scl_drv = (phase != PH_D);
        sda_drv = (phase == PH_A) || (phase == PH_B);
        if (phase_end) state_nx = c_byte ? S_DATA : (c_stop ? S_STOP : S_FIN);
      end
      S_DATA: begin
        busy     = 1'b1;
        scl_drv  = (phase == PH_B) || (phase == PH_C);
        sda_drv  = c_write ? sr_serial_o : 1'b1;
        sr_shift = phase_end;
        if (phase_end && bitcnt == 3'd0) state_nx = S_ACK;
      end
      S_ACK: begin
        busy    = 1'b1;
        scl_drv = (phase == PH_B) || (phase == PH_C);
        sda_drv = c_write ? 1'b1 : c_txack;
        if (phase_end) state_nx = c_stop ? S_STOP : S_FIN;
      end
      S_STOP: begin
        busy    = 1'b1;
        scl_drv = (phase != PH_A);
        sda_drv = (phase == PH_D);
        if (phase_end) state_nx = S_FIN;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= S_IDLE;  qcnt <= '0;  phase <= PH_A;  bitcnt <= 3'd0;
      c_byte <= 1'b0;   c_write <= 1'b0;  c_stop <= 1'b0;  c_txack <= 1'b0;
      scl_hold <= 1'b1; sda_hold <= 1'b1; rx_ack <= 1'b1;  sr_serial_i <= 1'b1;
    end else if (srst) begin
      state <= S_IDLE;  qcnt <= '0;  phase <= PH_A;  bitcnt <= 3'd0;
      c_byte <= 1'b0;   c_write <= 1'b0;  c_stop <= 1'b0;  c_txack <= 1'b0;
      scl_hold <= 1'b1; sda_hold <= 1'b1; rx_ack <= 1'b1;  sr_serial_i <= 1'b1;
    end else begin
      state    <= state_nx;
      scl_hold <= scl_drv;
      sda_hold <= sda_drv;
      if (accept) begin
        c_byte  <= cmd_write | cmd_read;
        c_write <= cmd_write;
        c_stop  <= cmd_stop;
        c_txack <= tx_ack;
      end
      if (state_nx != state) begin
        qcnt  <= '0;
        phase <= PH_A;
      end else if (phased && !stall) begin
        if (last_clk) begin
          qcnt  <= '0;
          phase <= phase + 2'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end
      if (state_nx == S_DATA && state != S_DATA) bitcnt <= 3'd7;
      else if (sr_shift && bitcnt != 3'd0)        bitcnt <= bitcnt - 3'd1;
      if (state == S_DATA && phase == PH_C && tick)            sr_serial_i <= sda_i;
      if (state == S_ACK && phase == PH_C && tick && c_write)  rx_ack <= sda_i;
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Directed + randomized bench for i2c_byte_ctrl with a shift-register/slave environment and a
// reference model built from command-level rules (latency formula, bit order, ACK and line levels).
module tb_i2c_byte_ctrl;
  logic        clk = 1'b0;
  logic        rst_, srst, cmd_valid, cmd_start, cmd_write, cmd_read, cmd_stop, tx_ack;
  logic [15:0] prescale;
  logic        cmd_ready, done, busy, rx_ack, sr_load, sr_shift, sr_serial_o, sr_serial_i;
  logic        scl_i, sda_i, scl_oen, sda_oen;
  logic [2:0]  state_dbg;

  int n_checks = 0, n_fail = 0, cyc = 0;

  i2c_byte_ctrl #(.PW(16)) dut (
    .clk(clk), .rst_(rst_), .srst(srst), .prescale(prescale),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_write(cmd_write),
    .cmd_read(cmd_read), .cmd_stop(cmd_stop), .tx_ack(tx_ack), .done(done), .busy(busy),
    .rx_ack(rx_ack), .sr_load(sr_load), .sr_shift(sr_shift), .sr_serial_o(sr_serial_o),
    .sr_serial_i(sr_serial_i), .scl_i(scl_i), .sda_i(sda_i), .scl_oen(scl_oen),
    .sda_oen(sda_oen), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external shift register
  logic [7:0] sr, data_load;
  always @(posedge clk) begin
    if (sr_load)       sr <= data_load;
    else if (sr_shift) sr <= {sr[6:0], sr_serial_i};
  end
  assign sr_serial_o = sr[7];

  // slave: slot n = number of SCL falls since the command was issued
  int   falls = 0, falls_base = 0, slot, st_cnt = 0, n_load = 0, n_shift = 0, n_done = 0;
  logic scl_prev = 1'b1, cur_write = 1'b0, cur_read = 1'b0, slave_ack = 1'b0;
  logic slave_rel, scl_rel = 1'b1, st_req = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int   rise_falls_q[$];
  logic rise_sda_q[$];

  assign slot = falls - falls_base;
  always_comb begin
    slave_rel = 1'b1;
    if (cur_read && slot >= 1 && slot <= 8) slave_rel = slave_byte[8 - slot];
    else if (cur_write && slot == 9)        slave_rel = slave_ack;
  end
  assign sda_i = sda_oen & slave_rel;
  assign scl_i = scl_oen & scl_rel;

  always @(negedge clk) begin
    scl_prev <= scl_oen;
    if (scl_prev && !scl_oen) falls <= falls + 1;
    if (!scl_prev && scl_oen) begin
      rise_falls_q.push_back(falls);
      rise_sda_q.push_back(sda_i);
    end
    if (sr_load)  n_load  <= n_load + 1;
    if (sr_shift) n_shift <= n_shift + 1;
    if (done)     n_done  <= n_done + 1;
    if (!st_req) begin
      st_cnt  <= 0;
      scl_rel <= 1'b1;
    end else if (slot == 1 && scl_oen && st_cnt < 20) begin
      st_cnt  <= st_cnt + 1;
      scl_rel <= 1'b0;
    end else begin
      scl_rel <= 1'b1;
    end
  end

  // reference model state
  logic rx_model, ln_scl, ln_sda;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string name, input bit s, input bit w, input bit r, input bit p,
                         input logic [7:0] d, input logic ta, input logic sack,
                         input bit stretch, input bit poke);
    bit b, rd;
    int q, exp_lat, acc, load0, shift0, done0, qi, lim, sl;
    logic [7:0] got;
    logic got_ack;
    b = w | r;
    rd = r & ~w;
    q = int'(prescale) + 1;
    exp_lat = (4 * s + 36 * b + 4 * p) * q + 1;
`ifdef I2C_CLK_STRETCH_EN
    if (stretch) exp_lat += 20;
`endif
    @(posedge clk); #1;
    data_load = d; slave_byte = d; cur_write = w; cur_read = rd; slave_ack = sack;
    st_req = stretch; tx_ack = ta; falls_base = falls; qi = rise_falls_q.size();
    cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p; cmd_valid = 1'b1;
    @(negedge clk);
    check({name, ":ready"}, cmd_ready, 1);
    acc = cyc; load0 = n_load; shift0 = n_shift; done0 = n_done;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0; cmd_read = 1'b0; cmd_stop = 1'b0;
    if (b || s || p) check({name, ":busy"}, busy, 1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 cmd_valid = 1'b1; cmd_write = 1'b1; cmd_start = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_write = 1'b0; cmd_start = 1'b0;
    end
    lim = 0;
    while (!done && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    if (w) rx_model = sack;
    if (p) begin ln_scl = 1'b1; ln_sda = 1'b1; end
    else if (b) begin ln_scl = 1'b0; ln_sda = w ? 1'b1 : ta; end
    else if (s) begin ln_scl = 1'b0; ln_sda = 1'b0; end
    check({name, ":timeout"}, lim < 5000, 1);
    check({name, ":latency"}, cyc - acc, exp_lat);
    check({name, ":n_load"}, n_load - load0, w);
    check({name, ":n_shift"}, n_shift - shift0, 8 * b);
    check({name, ":rx_ack"}, rx_ack, rx_model);
    check({name, ":scl_hold"}, scl_oen, ln_scl);
    check({name, ":sda_hold"}, sda_oen, ln_sda);
    if (b) begin
      got = 8'h00;
      got_ack = 1'bx;
      for (int i = qi; i < rise_falls_q.size(); i++) begin
        sl = rise_falls_q[i] - falls_base;
        if (sl >= 1 && sl <= 8) got[8 - sl] = rise_sda_q[i];
        else if (sl == 9)       got_ack = rise_sda_q[i];
      end
      if (w) begin
        check({name, ":sda_bits"}, got, d);
        check({name, ":ack_slot"}, got_ack, sack);
      end else begin
        check({name, ":rx_byte"}, sr, d);
        check({name, ":ack_slot"}, got_ack, ta);
      end
    end
    repeat (3) @(negedge clk);
    check({name, ":n_done"}, n_done - done0, 1);
    st_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ = 1'b0; srst = 1'b0; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
    cmd_read = 1'b0; cmd_stop = 1'b0; tx_ack = 1'b0; prescale = 16'd1; data_load = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst:scl_oen", scl_oen, 1);
    check("rst:sda_oen", sda_oen, 1);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:rx_ack", rx_ack, 1);
    check("rst:sr_serial_i", sr_serial_i, 1);
    check("rst:cmd_ready", cmd_ready, 1);
    check("rst:sr_shift", sr_shift, 0);
    rst_ = 1'b1;
    rx_model = 1'b1; ln_scl = 1'b1; ln_sda = 1'b1;

    prescale = 16'd1;
    run_cmd("wr_a5", 1, 1, 0, 1, 8'hA5, 1'b0, 1'b0, 0, 0);
    prescale = 16'd0;
    run_cmd("rd_3c", 0, 0, 1, 0, 8'h3C, 1'b1, 1'b0, 0, 1);
    run_cmd("empty", 0, 0, 0, 0, 8'h00, 1'b0, 1'b0, 0, 0);

    @(posedge clk); #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    rx_model = 1'b1; ln_scl = 1'b1; ln_sda = 1'b1;
    check("srst:scl_oen", scl_oen, 1);
    check("srst:sda_oen", sda_oen, 1);
    check("srst:rx_ack", rx_ack, 1);

    prescale = 16'd2;
    run_cmd("wr_ack", 0, 1, 0, 0, 8'(($urandom)), 1'b0, 1'b0, 0, 0);
    run_cmd("stop_only", 0, 0, 0, 1, 8'h00, 1'b0, 1'b0, 0, 0);
    run_cmd("wr_nack", 0, 1, 0, 0, 8'(($urandom)), 1'b0, 1'b1, 0, 0);
    prescale = 16'd1;
    run_cmd("stretch", 1, 1, 0, 1, 8'(($urandom)), 1'b0, 1'b0, 1, 0);

    for (int k = 0; k < 6; k++) begin
      prescale = 16'($urandom_range(0, 3));
      run_cmd("rand", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, 0);
    end

    // asynchronous reset in the middle of a byte
    prescale = 16'd1;
    run_cmd("wr_pre", 1, 1, 0, 1, 8'h5A, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    data_load = 8'hC3; cur_write = 1'b1; cur_read = 1'b0; falls_base = falls;
    cmd_start = 1'b1; cmd_write = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("mid:busy_before", busy, 1);
    rst_ = 1'b0;
    #1;
    check("mid:scl_oen", scl_oen, 1);
    check("mid:sda_oen", sda_oen, 1);
    check("mid:busy", busy, 0);
    check("mid:cmd_ready", cmd_ready, 1);
    check("mid:rx_ack", rx_ack, 1);
    @(posedge clk); #1 rst_ = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
